// File: rtl/ram_sp_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter.
// FSM state encodings, read pipeline depth, port identifiers and the
// read-tag record carried down the response pipeline.
package ram_sp_arbiter_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Edges from accept to rvalid: command register, then RAM output register.
    localparam int RD_LATENCY = 2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/ram_sp_sync_read.sv
// Single-port RAM with registered read (read-before-write on a shared address).
// Ports:
//   clk       clock
//   address   word address
//   data_in   write data
//   write_en  1 = write data_in to address on this edge
//   data_out  registered read data of address
module ram_sp_sync_read #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[address] <= data_in;
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter with a combinational grant.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   req[1:0]      requests, bit 0 = port A, bit 1 = port B
//   accept        an access was taken this cycle (advances the pointer)
//   enable        grants are suppressed while low
//   gnt[1:0]      one-hot (or zero) grant
module rr_arbiter_2
    import ram_sp_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr == PORT_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer moves away from whichever port just won, so a lone requester
    // hands priority to the other side for the next contested cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= PORT_A;
        end else if (accept && (gnt != 2'b00)) begin
            ptr <= gnt[0] ? PORT_B : PORT_A;
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one single-port registered-read RAM between requesters A and B.
// Clears the RAM after reset, then grants one access per cycle round-robin
// and returns read data with a per-port valid strobe.
// Ports:
//   clk, reset_n               clock and async active-low reset
//   req/we/addr/wdata_{a,b}    client requests (held until granted)
//   gnt_{a,b}                  combinational grants
//   rvalid_{a,b}, rdata        read response (rdata shared, from the RAM)
//   init_done                  clear sweep finished
//   ram_address/data_in/write_en  registered RAM command
//   ram_data_out               RAM read data
//
// state   | meaning
// ST_INIT | sweeping INIT_VALUE into every RAM word, no grants
// ST_RUN  | arbitrating client accesses
module ram_sp_arbiter
    import ram_sp_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    logic [0:0]          state;
    logic [ADDR_WIDTH:0] clr_cnt;
    logic [1:0]          gnt;
    logic                accept;
    logic                win_port;
    logic                win_we;
    rd_tag_t             tag_pipe [RD_LATENCY];

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req_b, req_a}),
        .accept  (accept),
        .enable  (state == ST_RUN),
        .gnt     (gnt)
    );

    assign gnt_a    = gnt[0];
    assign gnt_b    = gnt[1];
    assign accept   = |gnt;
    assign win_port = gnt[1] ? PORT_B : PORT_A;
    assign win_we   = (win_port == PORT_B) ? we_b : we_a;

    // The extra MSB on clr_cnt marks the end of the sweep, so the
    // address never wraps back to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT_EN ? ST_INIT : ST_RUN;
            init_done    <= !INIT_EN;
            clr_cnt      <= '0;
            ram_address  <= '0;
            ram_data_in  <= '0;
            ram_write_en <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (!clr_cnt[ADDR_WIDTH]) begin
                        ram_address  <= clr_cnt[ADDR_WIDTH-1:0];
                        ram_data_in  <= INIT_VALUE;
                        ram_write_en <= 1'b1;
                        clr_cnt      <= clr_cnt + 1'b1;
                    end else begin
                        ram_write_en <= 1'b0;
                        init_done    <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                default: begin
                    if (accept) begin
                        ram_address  <= (win_port == PORT_B) ? addr_b : addr_a;
                        ram_data_in  <= (win_port == PORT_B) ? wdata_b : wdata_a;
                        ram_write_en <= win_we;
                    end else begin
                        ram_write_en <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Stage 0 lines up with the RAM command register, the last stage with
    // the RAM output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= accept && !win_we;
            tag_pipe[0].port  <= win_port;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rvalid_a = tag_pipe[RD_LATENCY-1].valid && (tag_pipe[RD_LATENCY-1].port == PORT_A);
    assign rvalid_b = tag_pipe[RD_LATENCY-1].valid && (tag_pipe[RD_LATENCY-1].port == PORT_B);
    assign rdata    = ram_data_out;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Self-checking bench for ram_sp_arbiter with an attached ram_sp_sync_read.
module tb_ram_sp_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req_a, req_b, we_a, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
    logic [7:0] rdata;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in, ram_data_out;
    logic       ram_write_en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       q[$];
    logic [7:0] model [16];

    ram_sp_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .INIT_EN    (1'b1),
        .INIT_VALUE (8'h00)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_a        (req_a),
        .req_b        (req_b),
        .we_a         (we_a),
        .we_b         (we_b),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .wdata_a      (wdata_a),
        .wdata_b      (wdata_b),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .rvalid_a     (rvalid_a),
        .rvalid_b     (rvalid_b),
        .rdata        (rdata),
        .init_done    (init_done),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
        .ram_data_out (ram_data_out)
    );

    ram_sp_sync_read #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) u_ram (
        .clk      (clk),
        .address  (ram_address),
        .data_in  (ram_data_in),
        .write_en (ram_write_en),
        .data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rvalid must match the head of the scoreboard
    // in port, data and arrival cycle; a due entry with no rvalid is a miss.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a || rvalid_b) begin
            if (q.size() == 0) begin
                chk("spurious_rvalid", {rvalid_b, rvalid_a}, 2'b00);
            end else begin
                e = q.pop_front();
                chk("rvalid_port", {rvalid_b, rvalid_a}, e.port ? 2'b10 : 2'b01);
                chk("rdata", rdata, e.data);
                chk("rvalid_cycle", cyc, e.due);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("rvalid_missing", {rvalid_b, rvalid_a}, e.port ? 2'b10 : 2'b01);
        end
    end

    task automatic drive(input logic ra, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                         input logic rb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    endtask

    // One arbitration cycle: check grants against the expected winner and
    // update the model / scoreboard for the access the bench expects taken.
    task automatic cycle(input logic ega, input logic egb);
        @(negedge clk);
        chk("gnt_a", gnt_a, ega);
        chk("gnt_b", gnt_b, egb);
        if (ega) begin
            if (we_a) model[addr_a] = wdata_a;
            else      q.push_back('{1'b0, model[addr_a], cyc + 2});
        end
        if (egb) begin
            if (we_b) model[addr_b] = wdata_b;
            else      q.push_back('{1'b1, model[addr_b], cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset (requests left as driven), checks reset values,
    // releases it and follows the clear sweep edge by edge.
    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("reset_values", {ram_write_en, ram_address, ram_data_in, init_done, rvalid_a, rvalid_b}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            chk("sweep_edge", {ram_write_en, ram_address, ram_data_in, init_done, gnt_a, gnt_b},
                {1'b1, 4'(i), 8'h00, 3'b000});
        end
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk);
        #1;
        chk("init_done_edge17", {init_done, ram_write_en}, 2'b10);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
        do_reset();

        // A: write A5 to addr 3, then read it back on the next cycle.
        drive(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0);
        drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) cycle(1'b0, 1'b0);

        // Give addr 1 a distinct value, then B alone for 3 cycles.
        drive(1'b1, 1'b1, 4'd1, 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
        repeat (3) cycle(1'b0, 1'b1);

        // Both read for 4 cycles: pointer now on A, so A,B,A,B.
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) cycle(1'b0, 1'b0);

        // Same-address write/read with pointer on A: B sees the new value.
        drive(1'b1, 1'b1, 4'd5, 8'h11, 1'b1, 1'b0, 4'd5, 8'h00);
        cycle(1'b1, 1'b0);
        req_a = 1'b0;
        cycle(1'b0, 1'b1);
        req_b = 1'b0;

        // A lone A access moves the pointer to B.
        drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0);

        // Same-address write/read with pointer on B: B sees the old value.
        drive(1'b1, 1'b1, 4'd5, 8'h22, 1'b1, 1'b0, 4'd5, 8'h00);
        cycle(1'b0, 1'b1);
        req_b = 1'b0;
        cycle(1'b1, 1'b0);
        drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) cycle(1'b0, 1'b0);

        // Read accepted, then reset mid-flight: the response must vanish.
        drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0);
        do_reset();
        repeat (3) cycle(1'b0, 1'b0);

        // Post-sweep read of addr 3 returns the cleared value.
        drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) cycle(1'b0, 1'b0);

        chk("scoreboard_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
